// File: rtl/binary_adder_quiz_ctrl.sv
// binary_adder_quiz_ctrl
// Quiz controller for a 4-bit adder/subtractor trainer. A game asks ROUNDS
// questions; each question draws operands from an 8-bit LFSR, waits for the
// player's 5-bit answer, scores it and holds a feedback window.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous reset, active low
//   btn_pulse  - one-cycle buttons: [0]=start, [1]=submit, [4:2] unused
//   sw         - [4:0] player answer {flag,value}, [9:8] game mode (on start)
//   op_a/op_b  - operands driven to the adder datapath
//   op_mode    - 2'b10 add, 2'b11 subtract
//   round_idx  - 0-based index of the current question
//   score      - correct answers in the current game (saturating)
//   check_ok / check_fail / timeout - one-cycle verdict pulses
//   busy / done - game in progress / game finished
//
// Compile macro QUIZ_TIMEOUT_EN enables the per-question answer window of
// TIMEOUT_CYCLES cycles; without it WAIT_ANS waits indefinitely.
module binary_adder_quiz_ctrl #(
  parameter int unsigned ROUNDS          = 8,
  parameter int unsigned FEEDBACK_CYCLES = 50,
  parameter int unsigned TIMEOUT_CYCLES  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_pulse,
  input  logic [15:0] sw,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  output logic [1:0]  op_mode,
  output logic [7:0]  round_idx,
  output logic [7:0]  score,
  output logic        check_ok,
  output logic        check_fail,
  output logic        timeout,
  output logic        busy,
  output logic        done
);

  localparam int unsigned FB_W = $clog2(FEEDBACK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ANS = 3'd2,
    S_FEEDBACK = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        lfsr_q;
  logic [FB_W-1:0]   fb_cnt_q;

  logic              start_c, submit_c;
  logic [7:0]        lfsr_next_c;
  logic [4:0]        expected_c;
  logic              answer_ok_c;
  logic              fb_last_c;
  logic              last_round_c;
  logic              tmo_hit_c;
  logic              unused_c;

  assign start_c  = btn_pulse[0];
  assign submit_c = btn_pulse[1];

  // Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0
  assign lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // 5-bit expected answer: {carry,sum} for add, {borrow,diff} mod 32 for subtract
  assign expected_c  = (op_mode == 2'b11) ? (5'(op_a) - 5'(op_b))
                                          : (5'(op_a) + 5'(op_b));
  assign answer_ok_c = (sw[4:0] == expected_c);

  assign fb_last_c    = (fb_cnt_q == FB_W'(FEEDBACK_CYCLES - 1));
  assign last_round_c = ((round_idx + 8'd1) == 8'(ROUNDS));

  assign unused_c = ^{btn_pulse[4:2], sw[15:10], sw[7:5], 32'(TIMEOUT_CYCLES)};

`ifdef QUIZ_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;

  // Answer-window timer: cleared while issuing, counts every WAIT_ANS cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
    end else if (state_q == S_ISSUE) begin
      tmr_q <= '0;
    end else if (state_q == S_WAIT_ANS) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // A submit in the final window cycle takes priority over the timeout
  assign tmo_hit_c = (state_q == S_WAIT_ANS) && !submit_c &&
                     (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_c) state_d = S_ISSUE;
      S_ISSUE:        state_d = S_WAIT_ANS;
      S_WAIT_ANS:     if (submit_c || tmo_hit_c) state_d = S_FEEDBACK;
      S_FEEDBACK:     if (fb_last_c) state_d = last_round_c ? S_DONE : S_ISSUE;
      default:        state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 8'hA5;
      fb_cnt_q   <= '0;
      op_a       <= 4'd0;
      op_b       <= 4'd0;
      op_mode    <= 2'b10;
      round_idx  <= 8'd0;
      score      <= 8'd0;
      check_ok   <= 1'b0;
      check_fail <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      check_ok   <= 1'b0;
      check_fail <= 1'b0;
      timeout    <= 1'b0;
      busy       <= (state_d == S_ISSUE) || (state_d == S_WAIT_ANS) ||
                    (state_d == S_FEEDBACK);
      done       <= (state_d == S_DONE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_c) begin
            op_mode   <= (sw[9:8] == 2'b11) ? 2'b11 : 2'b10;
            score     <= 8'd0;
            round_idx <= 8'd0;
          end
        end
        S_ISSUE: begin
          op_a   <= lfsr_q[3:0];
          op_b   <= lfsr_q[7:4];
          lfsr_q <= lfsr_next_c;
        end
        S_WAIT_ANS: begin
          fb_cnt_q <= '0;
          if (submit_c) begin
            if (answer_ok_c) begin
              check_ok <= 1'b1;
              if (score != 8'hFF) score <= score + 8'd1;
            end else begin
              check_fail <= 1'b1;
            end
          end else if (tmo_hit_c) begin
            timeout    <= 1'b1;
            check_fail <= 1'b1;
          end
        end
        S_FEEDBACK: begin
          if (fb_last_c) begin
            round_idx <= round_idx + 8'd1;
          end else begin
            fb_cnt_q <= fb_cnt_q + FB_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/binary_adder_quiz_ctrl.md
BINARY_ADDER_QUIZ_CTRL -- requirements
Module: binary_adder_quiz_ctrl

Interface
REQ-001 Parameter ROUNDS, default 8, number of questions per game (1..255).
REQ-002 Parameter FEEDBACK_CYCLES, default 50, cycles the FEEDBACK state is held (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, default 500, per-question answer window in cycles (>=2); used only when QUIZ_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 btn_pulse  input  5  one-cycle button pulses: [0]=start, [1]=submit; [4:2] ignored.
REQ-007 sw  input  16  [4:0]=player answer {flag,value[3:0]}; [9:8]=game mode, sampled on start; other bits ignored.
REQ-008 op_a  output  4  operand A driven to the adder datapath.
REQ-009 op_b  output  4  operand B driven to the adder datapath.
REQ-010 op_mode  output  2  datapath mode, 2'b10 add or 2'b11 subtract.
REQ-011 round_idx  output  8  index of the current question, 0-based.
REQ-012 score  output  8  count of correct answers in the current game.
REQ-013 check_ok / check_fail  output  1 each  one-cycle verdict pulses.
REQ-014 timeout  output  1  one-cycle pulse when the answer window expires.
REQ-015 busy / done  output  1 each  busy=1 in ISSUE, WAIT_ANS and FEEDBACK; done=1 in DONE.

Function
REQ-016 FSM states are IDLE, ISSUE, WAIT_ANS, FEEDBACK and DONE.
REQ-017 In IDLE or DONE, start moves to ISSUE, latches op_mode, and clears score and round_idx.
REQ-018 op_mode latches 2'b11 when sw[9:8]==2'b11 and 2'b10 otherwise.
REQ-019 In all other states start is ignored.
REQ-020 ISSUE lasts 1 cycle: op_a<=lfsr[3:0], op_b<=lfsr[7:4], LFSR advances one step, next state WAIT_ANS.
REQ-021 LFSR is 8-bit Fibonacci with taps 8,6,5,4 (shift left, feedback into bit 0) and seed 8'hA5; it advances only in ISSUE.
REQ-022 Expected answer: add gives {carry,sum} = op_a+op_b, 5-bit; subtract gives {borrow,diff} = (op_a-op_b) mod 32, 5-bit.
REQ-023 In WAIT_ANS, submit compares sw[4:0] with the expected answer; the verdict pulse fires in the cycle after submit, and the next state is FEEDBACK.
REQ-024 A correct answer pulses check_ok and increments score, saturating at 255; a wrong answer pulses check_fail.
REQ-025 op_a and op_b stay stable from ISSUE through FEEDBACK.
REQ-026 FEEDBACK lasts exactly FEEDBACK_CYCLES cycles, then round_idx increments.
REQ-027 After FEEDBACK, if the incremented round_idx equals ROUNDS the FSM goes to DONE; otherwise it goes to ISSUE.
REQ-028 Submit outside WAIT_ANS is ignored.
REQ-029 If start and submit arrive together in WAIT_ANS, submit is processed and start is ignored.
REQ-030 In DONE, score and round_idx hold their final values until the next start.

Reset
REQ-031 Reset asserted forces: IDLE, lfsr=8'hA5, op_a=0, op_b=0, op_mode=2'b10, round_idx=0, score=0, all pulses 0, busy=0, done=0.
REQ-032 Reset asserted mid-game aborts the game immediately with no verdict pulse; state after release is identical to power-up.

Configuration
REQ-033 The compile macro QUIZ_TIMEOUT_EN controls the answer-window timer.
REQ-034 With QUIZ_TIMEOUT_EN defined: a timer clears on entry to WAIT_ANS and counts each WAIT_ANS cycle.
REQ-035 With QUIZ_TIMEOUT_EN defined: if the timer reaches TIMEOUT_CYCLES-1 without submit, the block pulses timeout and check_fail together and enters FEEDBACK, with score unchanged.
REQ-036 With QUIZ_TIMEOUT_EN defined: a submit in that same final cycle wins over the timeout.
REQ-037 Without QUIZ_TIMEOUT_EN: no timer logic exists, WAIT_ANS waits indefinitely, and timeout is tied to 0.

Verification
REQ-038 Reset release, no buttons -> all outputs at reset values for 10 cycles, done=0.
REQ-039 Start with sw[9:8]=10 -> op_a=5, op_b=10; submit sw[4:0]=5'd15 -> check_ok pulse, score=1.
REQ-040 Start with sw[9:8]=11 -> op_a=5, op_b=10; submit 5'd27 -> check_ok; submit 5'd5 instead -> check_fail, score=0.
REQ-041 ROUNDS=2, two correct answers -> done=1, score=2, round_idx=2; second start -> score=0, round_idx=0.
REQ-042 Start and submit together in WAIT_ANS -> exactly one verdict, no restart; reset asserted in FEEDBACK -> IDLE, score=0, no pulses.
REQ-043 QUIZ_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no submit -> timeout and check_fail pulse 4 cycles after WAIT_ANS entry, score unchanged; undefined -> no timeout after 1000 cycles.
